// File: rtl/fixed_point_divider_if.sv
// rtl/fixed_point_divider_if.sv - start/finish handshake and operand/result bundle for the divider
interface fixed_point_divider_if;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] result;
    logic        overflow_flag;
    logic        finish;
    logic        busy;

    modport master (
        output start, dividend, divisor,
        input  result, overflow_flag, finish, busy
    );

    modport slave (
        input  start, dividend, divisor,
        output result, overflow_flag, finish, busy
    );
endinterface

// File: rtl/fixed_point_divider.sv
// rtl/fixed_point_divider.sv - Q8.7 signed restoring divider, one quotient bit per cycle, round half away from zero
// Optional DIVIDER_SATURATE_EN: clamp out-of-range quotients instead of wrapping.
module fixed_point_divider (
    input  logic                  clk,
    input  logic                  rst,
    fixed_point_divider_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] LAST_ITER = 5'd24;

    logic [1:0]  state_q, state_d;
    logic [23:0] n_q, n_d;
    logic [15:0] d_q, d_d;
    logic [16:0] r_q, r_d;
    logic [23:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        dsgn_q, dsgn_d;
    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        finish_q, finish_d;

    logic        accept;
    logic [15:0] abs_a, abs_b;
    logic [17:0] r_shift, r_sub;
    logic        ge;
    logic [23:0] q_rnd;
    logic        out_of_range;
    logic [15:0] q_wrap, q_sat;

    assign accept = bus.start && (state_q != S_ITER);
    assign abs_a  = bus.dividend[15] ? (~bus.dividend + 16'd1) : bus.dividend;
    assign abs_b  = bus.divisor[15]  ? (~bus.divisor  + 16'd1) : bus.divisor;

    assign r_shift = {r_q, n_q[23]};
    assign ge      = r_shift >= {2'b00, d_q};
    assign r_sub   = r_shift - {2'b00, d_q};

    // (Q24 + 1) >> 1 without a carry-out bit
    assign q_rnd        = {1'b0, q_q[23:1]} + {23'd0, q_q[0]};
    assign out_of_range = neg_q ? (q_rnd > 24'd32768) : (q_rnd > 24'd32767);
    assign q_wrap       = neg_q ? (~q_rnd[15:0] + 16'd1) : q_rnd[15:0];
    assign q_sat        = neg_q ? 16'h8000 : 16'h7FFF;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        d_d      = d_q;
        r_d      = r_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        dsgn_d   = dsgn_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        finish_d = finish_q;

        if (accept) begin
            state_d  = S_ITER;
            n_d      = {abs_a, 8'h00};
            d_d      = abs_b;
            r_d      = 17'd0;
            q_d      = 24'd0;
            cnt_d    = 5'd0;
            neg_d    = bus.dividend[15] ^ bus.divisor[15];
            dz_d     = (bus.divisor == 16'h0000);
            dsgn_d   = bus.dividend[15];
            ovf_d    = 1'b0;
            finish_d = 1'b0;
        end else if (state_q == S_ITER) begin
            if (cnt_q == LAST_ITER) begin
                state_d  = S_DONE;
                finish_d = 1'b1;
                if (dz_q) begin
                    ovf_d    = 1'b1;
                    result_d = dsgn_q ? 16'h8000 : 16'h7FFF;
                end else if (out_of_range) begin
                    ovf_d    = 1'b1;
`ifdef DIVIDER_SATURATE_EN
                    result_d = q_sat;
`else
                    result_d = q_wrap;
`endif
                end else begin
                    ovf_d    = 1'b0;
                    result_d = q_wrap;
                end
            end else begin
                n_d   = {n_q[22:0], 1'b0};
                r_d   = 17'(ge ? r_sub : r_shift);
                q_d   = {q_q[22:0], ge};
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            d_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            dsgn_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            d_q      <= d_d;
            r_q      <= r_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            dsgn_q   <= dsgn_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            finish_q <= finish_d;
        end
    end

    assign bus.result        = result_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.finish        = finish_q;
    assign bus.busy          = (state_q == S_ITER);

`ifndef DIVIDER_SATURATE_EN
    logic unused_sat;
    assign unused_sat = ^q_sat;
`endif
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb/tb_fixed_point_divider.sv - scoreboard bench for fixed_point_divider
module tb_fixed_point_divider;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_point_divider_if dif ();
    fixed_point_divider dut (.clk(clk), .rst(rst), .bus(dif));

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];

`ifdef DIVIDER_SATURATE_EN
    localparam logic [15:0] OVF_POS = 16'h7FFF;
`else
    localparam logic [15:0] OVF_POS = 16'h8000;
`endif

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, ma, mb, q;
        logic neg, ovf;
        logic [15:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return {1'b1, (sa < 0) ? 16'h8000 : 16'h7FFF};
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        q   = (256 * ma + mb) / (2 * mb);
        neg = a[15] ^ b[15];
        ovf = neg ? (q > 32768) : (q > 32767);
        r   = 16'(neg ? -q : q);
`ifdef DIVIDER_SATURATE_EN
        if (ovf) r = neg ? 16'h8000 : 16'h7FFF;
`endif
        return {ovf, r};
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] e, input bit track);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        if (track) exp_q.push_back(e);
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = 16'($urandom);
        dif.divisor  = 16'($urandom);
    endtask

    task automatic wait_finish(output int lat);
        lat = 0;
        while (dif.finish !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (dif.finish !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.start = 1'b0; dif.dividend = 16'h0; dif.divisor = 16'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (dif.result !== 16'h0000) begin n_bad++; $display("FAIL reset_result got=%h exp=0000", dif.result); end
        n_cmp++; if (dif.overflow_flag !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", dif.overflow_flag); end
        n_cmp++; if (dif.finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish got=%b exp=0", dif.finish); end
        n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", dif.busy); end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [15:0] ta [11] = '{16'h00C0, 16'h0080, 16'hFF80, 16'h0001, 16'hFFFF, 16'h0000,
                                 16'h4000, 16'h8000, 16'hC000, 16'h0100, 16'hFF00};
        logic [15:0] tb [11] = '{16'h0040, 16'h0180, 16'h0180, 16'h0100, 16'h0100, 16'hFF00,
                                 16'h0040, 16'hFF80, 16'h0040, 16'h0000, 16'h0000};
        logic [16:0] te [11] = '{{1'b0, 16'h0180}, {1'b0, 16'h002B}, {1'b0, 16'hFFD5},
                                 {1'b0, 16'h0001}, {1'b0, 16'hFFFF}, {1'b0, 16'h0000},
                                 {1'b1, OVF_POS},  {1'b1, OVF_POS},  {1'b0, 16'h8000},
                                 {1'b1, 16'h7FFF}, {1'b1, 16'h8000}};
        int lat;
        logic [16:0] e;
        for (int i = 0; i < 11; i++) begin
            start_op(ta[i], tb[i], te[i], 1'b1);
            n_cmp++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL vec%0d_busy got=%b exp=1", i, dif.busy); end
            wait_finish(lat);
            n_cmp++; if (lat != 25) begin n_bad++; $display("FAIL vec%0d_latency got=%0d exp=25", i, lat); end
            e = exp_q.pop_front();
            n_cmp++; if (dif.result !== e[15:0]) begin n_bad++; $display("FAIL vec%0d_result %h/%h got=%h exp=%h", i, ta[i], tb[i], dif.result, e[15:0]); end
            n_cmp++; if (dif.overflow_flag !== e[16]) begin n_bad++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, dif.overflow_flag, e[16]); end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a, b;
        logic [16:0] e;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = (i < 4) ? 16'($urandom_range(1, 255)) : 16'($urandom);
            if (i == 9) b = 16'h8000;
            start_op(a, b, model(a, b), 1'b1);
            wait_finish(lat);
            e = exp_q.pop_front();
            n_cmp++; if (lat != 25) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=25", i, lat); end
            n_cmp++; if ({dif.overflow_flag, dif.result} !== e) begin n_bad++; $display("FAIL rnd%0d %h/%h got=%b,%h exp=%b,%h", i, a, b, dif.overflow_flag, dif.result, e[16], e[15:0]); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [16:0] e;
        start_op(16'h00C0, 16'h0040, {1'b0, 16'h0180}, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 16'h7000; dif.divisor = 16'h0001;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        n_cmp++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy got=%b exp=1", dif.busy); end
        wait_finish(lat);
        n_cmp++; if (lat + 6 != 25) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=25", lat + 6); end
        e = exp_q.pop_front();
        n_cmp++; if ({dif.overflow_flag, dif.result} !== e) begin n_bad++; $display("FAIL ignore_result got=%b,%h exp=%b,%h", dif.overflow_flag, dif.result, e[16], e[15:0]); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [16:0] e;
        start_op(16'h0100, 16'h0080, 17'h0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({dif.result, dif.overflow_flag, dif.finish, dif.busy} !== 19'h0) begin n_bad++; $display("FAIL midreset_outputs got=%h,%b,%b,%b exp=0", dif.result, dif.overflow_flag, dif.finish, dif.busy); end
        @(negedge clk);
        rst = 1'b0;
        start_op(16'h0100, 16'h0080, {1'b0, 16'h0100}, 1'b1);
        wait_finish(lat);
        e = exp_q.pop_front();
        n_cmp++; if (lat != 25) begin n_bad++; $display("FAIL after_reset_latency got=%0d exp=25", lat); end
        n_cmp++; if ({dif.overflow_flag, dif.result} !== e) begin n_bad++; $display("FAIL after_reset_result got=%b,%h exp=%b,%h", dif.overflow_flag, dif.result, e[16], e[15:0]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [16:0] e;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 16'h0080; dif.divisor = 16'h0180;
        exp_q.push_back({1'b0, 16'h002B});
        @(posedge clk);
        #1;
        dif.dividend = 16'h0100; dif.divisor = 16'h0080;
        exp_q.push_back({1'b0, 16'h0100});
        wait_finish(lat);
        e = exp_q.pop_front();
        n_cmp++; if (lat != 25) begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=25", lat); end
        n_cmp++; if ({dif.overflow_flag, dif.result} !== e) begin n_bad++; $display("FAIL b2b_first_result got=%b,%h exp=%b,%h", dif.overflow_flag, dif.result, e[16], e[15:0]); end
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        n_cmp++; if ({dif.finish, dif.busy} !== 2'b01) begin n_bad++; $display("FAIL b2b_restart got=finish%b,busy%b exp=finish0,busy1", dif.finish, dif.busy); end
        wait_finish(lat);
        e = exp_q.pop_front();
        n_cmp++; if (lat != 25) begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=25", lat); end
        n_cmp++; if ({dif.overflow_flag, dif.result} !== e) begin n_bad++; $display("FAIL b2b_second_result got=%b,%h exp=%b,%h", dif.overflow_flag, dif.result, e[16], e[15:0]); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
# fixed_point_divider

Sequential signed fixed-point divider for the ODE accelerator datapath. It is the inverse operation of the modified-Booth multiplier. It accepts 16-bit two's-complement operands with 7 fractional bits and computes dividend/divisor in the same format, one quotient bit per cycle. The result is rounded to nearest, with ties rounded away from zero. It uses the same start/finish handshake and overflow semantics as the multiplier, so the solver sequencer can drive both units identically.

## Interface
Parameters: none; the format is fixed at 16 bits total with 7 fractional bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  level-sampled request; accepted on a rising clk edge only while busy=0
- dividend  input  16  signed, 7 fractional bits; captured when start is accepted
- divisor  input  16  signed, 7 fractional bits; captured when start is accepted
- result  output  16  signed quotient, 7 fractional bits; registered
- overflow_flag  output  1  quotient not representable, or divide by zero; registered
- finish  output  1  result valid; held until the next start is accepted
- busy  output  1  a division is in progress

## Operation
- States and transitions:
  - IDLE: on start, go to ITER.
  - ITER: run 24 iterations, then go to DONE.
  - DONE: on start, go to ITER.
  - rst forces IDLE from any state.
- Accepting start (in IDLE or DONE):
  - Capture the operands.
  - Form magnitudes: N = |dividend| zero-extended to 16 bits, shifted left by 8, giving 24 bits (7 fractional-alignment bits plus 1 rounding bit). D = |divisor| as 16 bits, where |0x8000| = 32768.
  - neg = dividend[15] ^ divisor[15].
  - Clear finish and overflow_flag; set busy.
  - Clear the 17-bit partial remainder and the iteration counter.
- ITER, one bit per cycle, MSB first, restoring division:
  - r' = {r, next bit of N}.
  - If r' >= D, then r = r' - D and the quotient bit is 1.
  - Otherwise r = r' and the quotient bit is 0.
  - Produces a 24-bit quotient Q24.
- Finalise, on the transition into DONE:
  - q = (Q24 + 1) >> 1, a 24-bit magnitude rounded half away from zero.
  - Out of range when neg=0 and q > 32767, or when neg=1 and q > 32768.
  - If in range: result = neg ? -q : q, truncated to 16 bits. A zero q gives 0x0000 regardless of neg.
  - If out of range: overflow_flag = 1 and result follows the Configuration rules.
- Divide by zero (divisor == 0x0000):
  - The iteration still runs for uniform latency; its quotient is discarded.
  - Outputs overflow_flag = 1.
  - result = 0x7FFF if dividend[15] = 0, else 0x8000, in both configurations.
- start asserted while busy = 1 is ignored, and the operands are not re-captured.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset values: result = 0x0000, overflow_flag = 0, finish = 0, busy = 0, state = IDLE.
  - Reset takes effect immediately on rst assertion.
  - Reset mid-operation aborts the division with no partial result.
- start accepted at edge E:
  - busy = 1 after E.
  - Iterations occur on edges E+1 through E+24.
  - Finalise at E+25: finish = 1, busy = 0, and result and overflow_flag are valid after E+25.
  - Fixed latency of 25 cycles.
- finish, result and overflow_flag stay stable in DONE until the next accepted start. The next accepted start clears finish on that edge.
- Back-to-back operation: start held high in DONE starts the next division at the first DONE edge. Throughput is one division per 25 cycles.

## Configuration
- DIVIDER_SATURATE_EN defined: out-of-range results clamp to 0x7FFF (neg=0) or 0x8000 (neg=1).
- Undefined: out-of-range results take the low 16 bits of the signed rounded quotient (wrap), matching the multiplier's non-saturating behaviour.
- overflow_flag is asserted identically in both configurations.

## Test plan
- 0x00C0 / 0x0040 (1.5 / 0.5):
  - result 0x0180, overflow_flag 0.
  - finish rises exactly 25 cycles after start is accepted.
- 0x0080 / 0x0180 (1 / 3) gives result 0x002B. 0xFF80 / 0x0180 (-1 / 3) gives 0xFFD5. overflow_flag is 0 in both cases.
- Ties:
  - 0x0001 / 0x0100 gives 0x0001; 0xFFFF / 0x0100 gives 0xFFFF.
  - 0x0000 / 0xFF00 gives 0x0000.
- Overflow:
  - 0x4000 / 0x0040 gives overflow_flag 1, with result 0x7FFF (saturate) or 0x8000 (wrap).
  - 0x8000 / 0xFF80 gives overflow_flag 1.
  - 0xC000 / 0x0040 (-256) gives 0x8000 with no overflow.
- Divide by zero:
  - 0x0100 / 0x0000 gives 0x7FFF, overflow 1.
  - 0xFF00 / 0x0000 gives 0x8000, overflow 1.
  - Latency is still 25 cycles.
- Control:
  - Pulse start during iteration 5: it is ignored and the original result is unchanged.
  - Assert rst at iteration 10: all outputs go to 0 immediately.
  - A subsequent start of 0x0100 / 0x0080 completes with 0x0100.
